// File: rtl/data_mem_loader_pkg.sv
// Shared constants and FSM encoding for the byte-stream to TL-UL data memory loader.
package data_mem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StReq,
    StResp,
    StDone
  } loader_state_e;

  localparam tlul_pkg::tl_a_op_e LoaderOpcode = tlul_pkg::PutFullData;
  localparam logic [1:0]         LoaderSize   = 2'd2;
  localparam logic [3:0]         LoaderMask   = 4'hF;

  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned ByteCntW     = $clog2(BytesPerWord);

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions shared by hosts and devices on the data-memory bus.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/data_mem_loader_word_packer.sv
// Packs an 8-bit byte stream little-endian into 32-bit words; word_valid_o marks the final byte.
module word_packer
  import data_mem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [ByteCntW-1:0] cnt_q;
  logic [31:0]         word_q;
  logic                take;

  assign byte_ready_o = en_i;
  assign take         = en_i & byte_valid_i;
  assign word_valid_o = take && (cnt_q == ByteCntW'(BytesPerWord - 1));
  assign word_o       = word_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (take) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Word lanes hold their value while the FSM presents the word on the bus.
  always_ff @(posedge clk_i) begin
    if (take) begin
      word_q[{cnt_q, 3'b000} +: 8] <= byte_data_i;
    end
  end

endmodule

// File: rtl/data_mem_loader.sv
// Streams bytes into 32-bit words and writes each word to data memory with a TL-UL PutFullData.
module data_mem_loader
  import tlul_pkg::*;
  import data_mem_loader_pkg::*;
#(
  parameter logic [7:0]  SourceId    = 8'd0,
  parameter int unsigned RespTimeout = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [11:0] word_count_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned    TmoW    = $clog2(RespTimeout + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(RespTimeout - 1);

  loader_state_e   state_q, state_d;
  logic [29:0]     base_word_q;
  logic [11:0]     count_q;
  logic [11:0]     idx_q;
  logic [TmoW-1:0] tmo_q;
  logic            err_q;

  logic            start_acc;
  logic            idx_inc;
  logic            err_set;
  logic            last_word;
  logic            word_valid;
  logic [31:0]     word;
  logic            unused_tl;

  assign last_word = (idx_q == count_q - 12'd1);

  word_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (start_acc),
    .en_i         (state_q == StCollect),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    idx_inc   = 1'b0;
    err_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = (word_count_i == 12'd0) ? StDone : StCollect;
        end
      end
      StCollect: begin
        if (word_valid) state_d = StReq;
      end
      StReq: begin
        if (tl_i.a_ready) state_d = StResp;
      end
      StResp: begin
        if (tl_i.d_valid) begin
          if (tl_i.d_error) begin
            err_set = 1'b1;
            state_d = StDone;
          end else if (last_word) begin
            state_d = StDone;
          end else begin
            idx_inc = 1'b1;
            state_d = StCollect;
          end
        end else if (tmo_q == TmoLast) begin
          err_set = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        idx_q <= '0;
        err_q <= 1'b0;
      end else begin
        if (idx_inc) idx_q <= idx_q + 12'd1;
        if (err_set) err_q <= 1'b1;
      end
      // Counter restarts on every entry into RESP and counts cycles spent waiting.
      tmo_q <= (state_q == StResp && state_d == StResp) ? tmo_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_acc) begin
      base_word_q <= base_addr_i[31:2];
      count_q     <= word_count_i;
    end
  end

  // Word-granular addition keeps the byte address wrapping modulo 2^32.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (state_q == StReq);
    tl_o.a_opcode  = LoaderOpcode;
    tl_o.a_size    = LoaderSize;
    tl_o.a_mask    = LoaderMask;
    tl_o.a_source  = SourceId;
    tl_o.a_address = {base_word_q + 30'(idx_q), 2'b00};
    tl_o.a_data    = word;
    tl_o.d_ready   = (state_q == StResp);
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);
  assign err_o  = err_q;

  assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                       tl_i.d_sink, tl_i.d_data, base_addr_i[1:0]};

endmodule

// File: tb/tb_data_mem_loader.sv
// Randomized self-checking bench for data_mem_loader with a TL-UL device model and session-level reference.
module tb_data_mem_loader;
  import tlul_pkg::*;

  localparam logic [7:0] SRC = 8'h5A;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  op;
    logic [1:0]  size;
    logic [3:0]  mask;
    logic [7:0]  src;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [11:0] word_count_i = '0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = '0;
  logic        byte_ready_o;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i = '0;
  logic        busy_o, done_o, err_o;

  int n_cmp = 0;
  int n_fail = 0;

  beat_t      beats[$];
  logic [7:0] src_bytes[$];
  int         done_cnt, done_cyc, resp_entry_cyc, bytes_taken, unstable;
  logic       err_at_done, err_after_start;

  data_mem_loader #(.SourceId(SRC), .RespTimeout(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .word_count_i (word_count_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .tl_o         (tl_o),
    .tl_i         (tl_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_word(input int i);
    return {src_bytes[4*i+3], src_bytes[4*i+2], src_bytes[4*i+1], src_bytes[4*i]};
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
    return (base & 32'hFFFF_FFFC) + 32'(4 * i);
  endfunction

  // Runs one session: drives start, the byte stream from src_bytes and a TL-UL device, recording what happens.
  task automatic run_session(input logic [31:0] base, input logic [11:0] cnt, input int a_stall,
                             input int d_lat, input int err_at, input bit no_resp,
                             input bit gaps, input bit start_noise);
    int    cyc = 0;
    int    bi = 0;
    int    await_n = 0;
    int    rwait = 0;
    int    rnum = 0;
    bit    in_beat = 0;
    bit    prev_dready = 0;
    beat_t cur, snap;
    beats.delete();
    done_cnt = 0; done_cyc = -1; resp_entry_cyc = -1; unstable = 0;
    err_at_done = 1'bx; err_after_start = 1'bx;
    snap = '0;
    while (cyc < 3000) begin
      @(negedge clk);
      if (cyc == 1) err_after_start = err_o;
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; err_at_done = err_o; end
      end
      start_i      = (cyc == 0) || (start_noise && busy_o && $urandom_range(0, 3) == 0);
      base_addr_i  = (cyc == 0) ? base : $urandom;
      word_count_i = (cyc == 0) ? cnt : 12'($urandom);
      byte_valid_i = (bi < src_bytes.size()) && (!gaps || $urandom_range(0, 2) != 0);
      byte_data_i  = byte_valid_i ? src_bytes[bi] : 8'($urandom);
      if (byte_valid_i && byte_ready_o) bi++;
      if (tl_o.a_valid) begin
        cur = '{tl_o.a_address, tl_o.a_data, tl_o.a_opcode, tl_o.a_size, tl_o.a_mask, tl_o.a_source};
        if (in_beat && cur !== snap) unstable++;
        if (!in_beat) begin snap = cur; in_beat = 1; end
        tl_i.a_ready = (await_n >= a_stall);
        if (tl_i.a_ready) begin beats.push_back(cur); in_beat = 0; await_n = 0; end
        else await_n++;
      end else begin
        tl_i.a_ready = 1'($urandom_range(0, 1));
        in_beat = 0;
      end
      if (tl_o.d_ready) begin
        if (!prev_dready) begin resp_entry_cyc = cyc; rwait = 0; end
        tl_i.d_valid = !no_resp && (rwait >= d_lat);
        tl_i.d_error = tl_i.d_valid && (rnum == err_at);
        tl_i.d_data  = $urandom;
        if (tl_i.d_valid) begin rnum++; rwait = 0; end
        else rwait++;
      end else begin
        tl_i.d_valid = 1'b0;
        tl_i.d_error = 1'b0;
      end
      prev_dready = tl_o.d_ready;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      cyc++;
    end
    bytes_taken = bi;
    start_i = 1'b0; byte_valid_i = 1'b0; tl_i = '0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({byte_ready_o, busy_o, done_o, err_o, tl_o.a_valid, tl_o.d_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {byte_ready_o, busy_o, done_o, err_o, tl_o.a_valid, tl_o.d_ready});
    end
    rst_i = 1'b0;
    byte_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({byte_ready_o, busy_o, tl_o.a_valid} !== 3'b0) begin
        n_fail++;
        $display("FAIL idle_quiet: got %b expected 000", {byte_ready_o, busy_o, tl_o.a_valid});
      end
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic test_basic;
    src_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    run_session(32'h100, 12'd2, 0, 0, -1, 0, 0, 0);
    n_cmp++; if (beats.size() != 2) begin n_fail++; $display("FAIL basic_beats: got %0d expected 2", beats.size()); end
    if (beats.size() == 2) begin
      n_cmp++; if (beats[0].data !== 32'h44332211) begin n_fail++; $display("FAIL basic_data0: got %h expected 44332211", beats[0].data); end
      n_cmp++; if (beats[0].addr !== 32'h100) begin n_fail++; $display("FAIL basic_addr0: got %h expected 00000100", beats[0].addr); end
      n_cmp++; if (beats[1].data !== 32'h88776655) begin n_fail++; $display("FAIL basic_data1: got %h expected 88776655", beats[1].data); end
      n_cmp++; if (beats[1].addr !== 32'h104) begin n_fail++; $display("FAIL basic_addr1: got %h expected 00000104", beats[1].addr); end
      n_cmp++;
      if ({beats[1].op, beats[1].size, beats[1].mask, beats[1].src} !== {3'd0, 2'd2, 4'hF, SRC}) begin
        n_fail++;
        $display("FAIL basic_hdr: got op=%0d size=%0d mask=%h src=%h expected op=0 size=2 mask=f src=%h",
                 beats[1].op, beats[1].size, beats[1].mask, beats[1].src, SRC);
      end
    end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt); end
    n_cmp++; if (err_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", err_at_done); end
    n_cmp++; if (bytes_taken != 8) begin n_fail++; $display("FAIL basic_bytes: got %0d expected 8", bytes_taken); end
  endtask

  task automatic test_a_ready_stall;
    src_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_session(32'h100, 12'd2, 5, 1, -1, 0, 0, 0);
    n_cmp++; if (unstable != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes expected 0", unstable); end
    n_cmp++; if (beats.size() != 2) begin n_fail++; $display("FAIL stall_beats: got %0d expected 2", beats.size()); end
    if (beats.size() == 2) begin
      n_cmp++; if (beats[1].data !== 32'h88776655 || beats[1].addr !== 32'h104) begin
        n_fail++; $display("FAIL stall_word1: got %h@%h expected 88776655@00000104", beats[1].data, beats[1].addr);
      end
    end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_d_error;
    src_bytes.delete();
    for (int i = 0; i < 12; i++) src_bytes.push_back(8'($urandom));
    run_session(32'h2000, 12'd3, 0, 2, 1, 0, 1, 0);
    n_cmp++; if (err_at_done !== 1'b1) begin n_fail++; $display("FAIL derr_err: got %b expected 1", err_at_done); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL derr_done: got %0d expected 1", done_cnt); end
    n_cmp++; if (beats.size() != 2) begin n_fail++; $display("FAIL derr_beats: got %0d expected 2", beats.size()); end
    n_cmp++; if (bytes_taken != 8) begin n_fail++; $display("FAIL derr_bytes: got %0d expected 8", bytes_taken); end
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL derr_sticky: got %b expected 1", err_o); end
    src_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_session(32'h3000, 12'd1, 0, 0, -1, 0, 0, 0);
    n_cmp++; if (err_after_start !== 1'b0) begin n_fail++; $display("FAIL derr_clear: got %b expected 0", err_after_start); end
    n_cmp++; if (err_at_done !== 1'b0) begin n_fail++; $display("FAIL derr_next_err: got %b expected 0", err_at_done); end
  endtask

  task automatic test_timeout;
    src_bytes.delete();
    for (int i = 0; i < 8; i++) src_bytes.push_back(8'($urandom));
    run_session(32'h400, 12'd2, 0, 0, -1, 1, 0, 0);
    n_cmp++; if (err_at_done !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", err_at_done); end
    n_cmp++; if (done_cyc - resp_entry_cyc != 16) begin
      n_fail++; $display("FAIL tmo_latency: got %0d cycles expected 16", done_cyc - resp_entry_cyc);
    end
    n_cmp++; if (beats.size() != 1) begin n_fail++; $display("FAIL tmo_beats: got %0d expected 1", beats.size()); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL tmo_done: got %0d expected 1", done_cnt); end
    @(negedge clk); rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0;
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL tmo_rst_err: got %b expected 0", err_o); end
  endtask

  task automatic test_zero_and_wrap;
    src_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_session(32'h500, 12'd0, 0, 0, -1, 0, 0, 0);
    n_cmp++; if (done_cyc != 1) begin n_fail++; $display("FAIL zero_latency: got %0d expected 1", done_cyc); end
    n_cmp++; if (beats.size() != 0 || bytes_taken != 0) begin
      n_fail++; $display("FAIL zero_activity: got beats=%0d bytes=%0d expected 0/0", beats.size(), bytes_taken);
    end
    src_bytes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    run_session(32'hFFFF_FFFC, 12'd2, 1, 1, -1, 0, 1, 0);
    n_cmp++; if (beats.size() != 2) begin n_fail++; $display("FAIL wrap_beats: got %0d expected 2", beats.size()); end
    if (beats.size() == 2) begin
      n_cmp++; if (beats[0].addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h expected fffffffc", beats[0].addr); end
      n_cmp++; if (beats[1].addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1: got %h expected 00000000", beats[1].addr); end
    end
    src_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_session(32'h0000_0107, 12'd1, 0, 0, -1, 0, 0, 0);
    n_cmp++; if (beats.size() != 1 || beats[0].addr !== 32'h104) begin
      n_fail++; $display("FAIL align_addr: got %0d beats first=%h expected 1 beat at 00000104",
                         beats.size(), beats.size() ? beats[0].addr : 32'h0);
    end
  endtask

  task automatic test_reset_mid;
    bit saw_done = 0;
    @(negedge clk); start_i = 1'b1; base_addr_i = 32'h200; word_count_i = 12'd1;
    @(negedge clk); start_i = 1'b0; byte_valid_i = 1'b1; byte_data_i = 8'hAA;
    @(negedge clk); byte_data_i = 8'hBB;
    @(negedge clk); byte_valid_i = 1'b0; rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0;
    n_cmp++;
    if ({byte_ready_o, busy_o, done_o, err_o, tl_o.a_valid, tl_o.d_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %b expected 000000",
               {byte_ready_o, busy_o, done_o, err_o, tl_o.a_valid, tl_o.d_ready});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_o) saw_done = 1;
    end
    n_cmp++; if (saw_done) begin n_fail++; $display("FAIL midrst_done: got done pulse expected none"); end
    src_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_session(32'h200, 12'd1, 0, 0, -1, 0, 0, 0);
    n_cmp++; if (beats.size() != 1 || beats[0].data !== 32'h04030201) begin
      n_fail++; $display("FAIL midrst_repack: got %0d beats first=%h expected 1 beat 04030201",
                         beats.size(), beats.size() ? beats[0].data : 32'h0);
    end
  endtask

  task automatic test_random;
    for (int s = 0; s < 8; s++) begin
      logic [31:0] base = $urandom;
      int cnt   = $urandom_range(1, 5);
      int err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, cnt - 1) : -1;
      int n_exp = (err_at >= 0) ? err_at + 1 : cnt;
      src_bytes.delete();
      for (int i = 0; i < 4 * cnt + 3; i++) src_bytes.push_back(8'($urandom));
      run_session(base, 12'(cnt), $urandom_range(0, 3), $urandom_range(0, 6), err_at, 0, 1, 1);
      n_cmp++; if (beats.size() != n_exp) begin
        n_fail++; $display("FAIL rnd%0d_beats: got %0d expected %0d", s, beats.size(), n_exp);
      end
      for (int i = 0; i < n_exp && i < beats.size(); i++) begin
        n_cmp++;
        if (beats[i].addr !== exp_addr(base, i) || beats[i].data !== exp_word(i) ||
            {beats[i].op, beats[i].size, beats[i].mask, beats[i].src} !== {3'd0, 2'd2, 4'hF, SRC}) begin
          n_fail++;
          $display("FAIL rnd%0d_word%0d: got %h@%h expected %h@%h", s, i,
                   beats[i].data, beats[i].addr, exp_word(i), exp_addr(base, i));
        end
      end
      n_cmp++; if (err_at_done !== (err_at >= 0)) begin
        n_fail++; $display("FAIL rnd%0d_err: got %b expected %b", s, err_at_done, err_at >= 0);
      end
      n_cmp++; if (done_cnt != 1 || bytes_taken != 4 * n_exp || unstable != 0) begin
        n_fail++; $display("FAIL rnd%0d_session: got done=%0d bytes=%0d unstable=%0d expected 1/%0d/0",
                           s, done_cnt, bytes_taken, unstable, 4 * n_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_a_ready_stall();
    test_d_error();
    test_timeout();
    test_zero_and_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
